// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the streaming NxN convolution datapath: gates and flushes the
// sliding window, tags results with (x,y) and holds a double-buffered signed kernel.
module conv_frame_ctrl #(
  parameter int  SIZE         = 3,
  parameter int  LINE_WIDTH   = 640,
  parameter int  FRAME_HEIGHT = 480,
  parameter int  KERNEL_WIDTH = 8,
  parameter int  PIPE_DELAY   = (SIZE-1)*LINE_WIDTH + (SIZE-1),
  localparam int TOTAL        = LINE_WIDTH*FRAME_HEIGHT,
  localparam int AW           = $clog2(SIZE*SIZE),
  localparam int XW           = $clog2(LINE_WIDTH),
  localparam int YW           = $clog2(FRAME_HEIGHT),
  localparam int CW           = $clog2(TOTAL+PIPE_DELAY+1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sof_i,
  input  logic                           pix_valid_i,
  output logic                           conv_en_o,
  output logic                           pix_zero_o,
  input  logic                           conv_valid_i,
  output logic                           out_valid_o,
  output logic [XW-1:0]                  out_x_o,
  output logic [YW-1:0]                  out_y_o,
  output logic                           frame_done_o,
  output logic                           busy_o,
  input  logic                           cfg_we_i,
  input  logic [AW-1:0]                  cfg_addr_i,
  input  logic signed [KERNEL_WIDTH-1:0] cfg_data_i,
  input  logic                           cfg_commit_i,
  output logic                           cfg_pending_o,
  output logic signed [KERNEL_WIDTH-1:0] kernel_o [0:SIZE-1][0:SIZE-1],
  output logic                           err_o,
  input  logic                           err_clr_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_e;

  localparam int            CTR         = (SIZE-1)/2;
  localparam logic [CW-1:0] K_LAST_PIX  = CW'(TOTAL-1);
  localparam logic [CW-1:0] K_LAST_EN   = CW'(TOTAL+PIPE_DELAY-1);
  localparam logic [CW-1:0] K_FIRST_TAG = CW'(PIPE_DELAY);

  state_e        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [XW-1:0] tx_q, tx_d, out_x_q;
  logic [YW-1:0] ty_q, ty_d, out_y_q;
  logic          out_valid_q, frame_done_q;
  logic          err_q, err_d, pend_q, pend_d;
  logic          sof_qual, tag_en, last_tag, x_wrap;
  logic signed [KERNEL_WIDTH-1:0] shadow_q [0:SIZE-1][0:SIZE-1];
  logic signed [KERNEL_WIDTH-1:0] shadow_d [0:SIZE-1][0:SIZE-1];
  logic signed [KERNEL_WIDTH-1:0] active_q [0:SIZE-1][0:SIZE-1];
  logic signed [KERNEL_WIDTH-1:0] active_d [0:SIZE-1][0:SIZE-1];

  assign sof_qual = sof_i & pix_valid_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every variable assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sof_qual) state_d = S_ACTIVE;
      S_ACTIVE: if (pix_valid_i && k_q == K_LAST_PIX) state_d = S_DRAIN;
      S_DRAIN:  if (k_q == K_LAST_EN) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    conv_en_o  = 1'b0;
    pix_zero_o = 1'b0;
    case (state_q)
      S_IDLE:   conv_en_o = sof_qual;
      S_ACTIVE: conv_en_o = pix_valid_i;
      S_DRAIN: begin
        conv_en_o  = 1'b1;
        pix_zero_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Results are tagged only once the window has been filled by this frame's pixels.
  assign tag_en   = conv_en_o && (k_q >= K_FIRST_TAG);
  assign x_wrap   = (tx_q == XW'(LINE_WIDTH-1));
  assign last_tag = x_wrap && (ty_q == YW'(FRAME_HEIGHT-1));

  always_comb begin
    k_d  = k_q;
    tx_d = tx_q;
    ty_d = ty_q;
    if (conv_en_o) k_d = (k_q == K_LAST_EN) ? '0 : k_q + CW'(1);
    if (tag_en) begin
      if (x_wrap) begin
        tx_d = '0;
        ty_d = last_tag ? '0 : ty_q + YW'(1);
      end else begin
        tx_d = tx_q + XW'(1);
      end
    end
  end

  // Setting the error wins over a same-cycle clear.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if ((out_valid_q && !conv_valid_i) || (sof_qual && state_q != S_IDLE)) err_d = 1'b1;
  end

  // The copy takes shadow_d so a write in the commit cycle is included.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we_i) begin
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          if (cfg_addr_i == AW'(i*SIZE+j)) shadow_d[i][j] = cfg_data_i;
    end
    active_d = active_q;
    pend_d   = pend_q | cfg_commit_i;
    if (state_q == S_IDLE && pend_d) begin
      active_d = shadow_d;
      pend_d   = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q          <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      k_q          <= k_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      out_valid_q  <= tag_en;
      frame_done_q <= tag_en && last_tag;
      err_q        <= err_d;
      pend_q       <= pend_d;
      if (tag_en) begin
        out_x_q <= tx_q;
        out_y_q <= ty_q;
      end
    end
  end

  // NOTE: the kernel arrays are plain flops whose reset value (identity) is visible
  // on kernel_o, so unlike a RAM they are reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++) begin
          shadow_q[i][j] <= (i == CTR && j == CTR) ? KERNEL_WIDTH'(1) : '0;
          active_q[i][j] <= (i == CTR && j == CTR) ? KERNEL_WIDTH'(1) : '0;
        end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_x_o       = out_x_q;
  assign out_y_o       = out_y_q;
  assign frame_done_o  = frame_done_q;
  assign busy_o        = (state_q != S_IDLE);
  assign cfg_pending_o = pend_q;
  assign err_o         = err_q;
  assign kernel_o      = active_q;

endmodule
